router_fifo: RTL and testbench
==============================

Name: router_fifo

Overview:
Per-port output FIFO of the 1x3 router, directly downstream of the synchronizer. It consumes one bit of the synchronizer's write_enb, its fifo-side soft reset and the header-marker from the router FSM. It returns empty/full, which the synchronizer turns into vld_out and fifo_full. The FIFO also tracks the packet being drained so that the read side knows when the packet ends.

Parameters:
DATA_W, 8, payload byte width
DEPTH, 16, number of entries (power of two)
ADDR_W, 4, log2(DEPTH)

Ports:
clock  in  1  single clock, all state updates on rising edge
reset  in  1  synchronous, active-high; sampled on rising edge of clock
soft_reset  in  1  synchronous active-high flush from synchronizer (soft_rst0/1/2)
write_enb  in  1  write strobe (one bit of synchronizer write_enb)
read_enb  in  1  read strobe from downstream consumer
lfd_state  in  1  high in the same cycle as the header byte on data_in
data_in  in  DATA_W  byte to store
data_out  out  DATA_W  registered read data
full  out  1  DEPTH entries stored
empty  out  1  no entries stored
pkt_busy  out  1  pkt_cnt != 0 (packet partially drained)

Behaviour:
- Storage: DEPTH x (DATA_W+1) entries; bit DATA_W holds the header flag, and bits DATA_W-1:0 hold the byte.
- Pointers wr_ptr and rd_ptr are ADDR_W+1 bits wide and wrap naturally mod 2*DEPTH. The low ADDR_W bits index the memory.
- empty = (wr_ptr == rd_ptr).
- full = (MSBs differ) and (low ADDR_W bits equal).
- Both flags are combinational from registered pointers; there are no other flag registers.
- Priority per cycle: reset > soft_reset > normal read/write.
- Reset and soft_reset clear wr_ptr, rd_ptr, pkt_cnt and data_out (all 0). They give empty=1, full=0, pkt_busy=0 in the following cycle. Memory contents are not cleared.
- Write: if write_enb && !full, then mem[wr_ptr] <= {lfd_state, data_in} and wr_ptr <= wr_ptr+1. A write while full is dropped silently, with no pointer change.
- Read: if read_enb && !empty, then data_out <= mem[rd_ptr] byte and rd_ptr <= rd_ptr+1. Latency is one cycle: the byte appears on data_out the cycle after the read_enb edge.
- A read while empty is ignored, and data_out holds its value.
- data_out holds its last value whenever no valid read occurs.
- Packet counter pkt_cnt is 7 bits:
  - On a valid read of an entry with header flag=1: pkt_cnt <= byte[7:2] + 1, covering payload length plus parity. The add is zero-extended, so len=63 gives 64.
  - On a valid read of a non-header entry with pkt_cnt != 0: pkt_cnt <= pkt_cnt - 1.
  - pkt_cnt never underflows: a non-header read with pkt_cnt=0 leaves it at 0.
- Simultaneous read and write:
  - Both take effect when !empty and !full.
  - When full, the read proceeds and the write is dropped (full is evaluated on pre-edge pointers).
  - When empty, the write proceeds and the read is ignored. There is no fall-through.
- soft_reset asserted mid-packet discards all stored bytes, including a partially written packet. Writes in the soft_reset cycle are dropped.

Decomposition:
- Shared package router_pkg holds:
  - DATA_W = 8 and FIFO_DEPTH = 16.
  - Header field positions: HDR_ADDR = [1:0], HDR_LEN = [7:2].
  - Synchronizer address encodings 2'b00/01/10.
- No sub-module; the memory array, pointer logic and packet counter stay inline.

Test Plan:
1. Reset -> assert reset for 2 cycles -> empty=1, full=0, data_out=8'h00, pkt_busy=0.
2. Single packet:
   - Stimulus: write 8'h0D with lfd=1 (len 3, addr 01), then 8'hA1, 8'hA2, 8'hA3 and parity 8'h5F with lfd=0; then read 5 consecutive cycles.
   - Response: data_out = 0D, A1, A2, A3, 5F, each one cycle after its read_enb; pkt_cnt = 4, 3, 2, 1, 0; empty=1 after the last read.
3. Full boundary:
   - Stimulus: write 16 bytes 8'h00..8'h0F, then a 17th write 8'hFF; then read 16.
   - Response: full=1 after the 16th write; the 17th write is dropped; reads return 00..0F in order; empty=1 at the end.
4. Simultaneous read and write at full: full FIFO, read_enb=1 and write_enb=1 with 8'hEE in the same cycle -> next cycle full=0 (15 entries); 8'hEE is never read back.
5. Soft reset mid-packet:
   - Stimulus: write header plus 2 bytes, read 1 (pkt_busy=1), then pulse soft_reset together with write_enb.
   - Response: next cycle empty=1, pkt_busy=0, data_out=00; a later read_enb produces no data change.
6. Pointer wrap:
   - Stimulus: interleave 40 writes of an incrementing byte with reads, keeping occupancy between 1 and 15.
   - Response: every byte is read back in order across two pointer wraps; full and empty never assert spuriously.

Source files
------------

// File: rtl/router_pkg.sv
// router_pkg: definitions shared across the 1x3 router slice.
//   DATA_W / FIFO_DEPTH     : payload byte width and per-port FIFO depth
//   HDR_ADDR_* / HDR_LEN_*  : bit positions of the address and length fields
//                             inside the header byte
//   dest_addr_e             : destination-port encodings used by the synchronizer
//   pkt_len_from_hdr        : bytes still to drain after a header is read
//                             (payload length plus the parity byte)
package router_pkg;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 16;

  // Header byte layout: [7:2] payload length, [1:0] destination address
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_LEN_MSB  = 7;

  // Wide enough for a length of 63 plus one parity byte (64)
  localparam int PKT_CNT_W = 7;

  typedef enum logic [1:0] {
    DEST_PORT0 = 2'b00,
    DEST_PORT1 = 2'b01,
    DEST_PORT2 = 2'b10
  } dest_addr_e;

  // Zero-extended, so a length of 63 yields 64 rather than wrapping
  function automatic logic [PKT_CNT_W-1:0] pkt_len_from_hdr(input logic [DATA_W-1:0] hdr);
    return PKT_CNT_W'(hdr[HDR_LEN_MSB:HDR_LEN_LSB]) + PKT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/router_fifo.sv
// router_fifo: per-port output FIFO of the 1x3 router.
// Each entry stores the data byte plus a header flag captured from lfd_state.
// The read side tracks how much of the current packet remains to be drained.
//   clock      : single clock, rising edge
//   reset      : synchronous active-high reset
//   soft_reset : synchronous active-high flush from the synchronizer
//   write_enb  : write strobe; dropped when full
//   read_enb   : read strobe; ignored when empty
//   lfd_state  : marks data_in as a header byte
//   data_in    : byte to store
//   data_out   : registered read data, valid the cycle after a read
//   full       : DEPTH entries stored
//   empty      : no entries stored
//   pkt_busy   : a packet is partially drained
module router_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              pkt_busy
);

  import router_pkg::*;

  logic [DATA_W:0]    mem [DEPTH];
  logic [ADDR_W:0]    wr_ptr;
  logic [ADDR_W:0]    rd_ptr;
  logic [PKT_CNT_W-1:0] pkt_cnt;

  logic            wr_fire;
  logic            rd_fire;
  logic [DATA_W:0] rd_entry;

  // Extra pointer MSB distinguishes full from empty when the indices match
  always_comb begin
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
               (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    pkt_busy = (pkt_cnt != '0);
  end

  // Both strobes are qualified on pre-edge flags and suppressed by either reset
  always_comb begin
    wr_fire  = write_enb && !full  && !reset && !soft_reset;
    rd_fire  = read_enb  && !empty && !reset && !soft_reset;
    rd_entry = mem[rd_ptr[ADDR_W-1:0]];
  end

  // Storage is deliberately left uncleared by either reset
  always_ff @(posedge clock) begin
    if (wr_fire)
      mem[wr_ptr[ADDR_W-1:0]] <= {lfd_state, data_in};
  end

  always_ff @(posedge clock) begin
    if (reset || soft_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      data_out <= '0;
    end else begin
      if (wr_fire)
        wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
      if (rd_fire) begin
        rd_ptr   <= rd_ptr + (ADDR_W+1)'(1);
        data_out <= rd_entry[DATA_W-1:0];
        if (rd_entry[DATA_W])
          pkt_cnt <= pkt_len_from_hdr(rd_entry[DATA_W-1:0]);
        else if (pkt_cnt != '0)
          pkt_cnt <= pkt_cnt - PKT_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo: directed scoreboard bench for router_fifo.
// Stimulus pushes expected read responses into a queue; a monitor pops and
// compares each time the DUT performs a read.
module tb_router_fifo;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       soft_reset = 1'b0;
  logic       write_enb = 1'b0;
  logic       read_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       pkt_busy;

  router_fifo #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty),
    .pkt_busy   (pkt_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    logic       busy;
  } exp_t;

  exp_t        exp_q[$];
  logic [8:0]  model_q[$];
  int unsigned model_pkt = 0;
  logic [7:0]  model_dout = '0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle of stimulus: drive at negedge, update the model with the
  // pre-edge state, then compare flags/data just after the rising edge.
  task automatic step(input logic rst, input logic sr, input logic we, input logic re,
                      input logic lfd, input logic [7:0] din);
    logic       rd_ok;
    logic       wr_ok;
    logic [8:0] e;
    @(negedge clock);
    reset = rst; soft_reset = sr; write_enb = we; read_enb = re;
    lfd_state = lfd; data_in = din;
    if (rst || sr) begin
      model_q.delete();
      model_pkt  = 0;
      model_dout = '0;
    end else begin
      rd_ok = re && (model_q.size() != 0);
      wr_ok = we && (model_q.size() < 16);
      if (rd_ok) begin
        e = model_q.pop_front();
        model_dout = e[7:0];
        if (e[8])
          model_pkt = int'(e[7:2]) + 1;
        else if (model_pkt != 0)
          model_pkt--;
        exp_q.push_back('{data: e[7:0], busy: (model_pkt != 0)});
      end
      if (wr_ok)
        model_q.push_back({lfd, din});
    end
    @(posedge clock);
    #1;
    reset = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0; lfd_state = 1'b0;
    check1("empty", empty, model_q.size() == 0);
    check1("full", full, model_q.size() == 16);
    check1("pkt_busy", pkt_busy, model_pkt != 0);
    check8("data_out", data_out, model_dout);
  endtask

  task automatic wr(input logic lfd, input logic [7:0] din);
    step(1'b0, 1'b0, 1'b1, 1'b0, lfd, din);
  endtask

  task automatic rd();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  // Monitor: a read presented at an edge yields data one cycle later
  initial begin : monitor
    logic fire;
    exp_t e;
    forever begin
      @(posedge clock);
      fire = (read_enb === 1'b1) && (empty === 1'b0) && !reset && !soft_reset;
      #1;
      if (fire) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL mon_unexpected: got read data %02h expected no read at %0t", data_out, $time);
        end else begin
          e = exp_q.pop_front();
          check8("mon_data", data_out, e.data);
          check1("mon_busy", pkt_busy, e.busy);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [7:0] t2_bytes [5] = '{8'h0D, 8'hA1, 8'hA2, 8'hA3, 8'h5F};
  logic       t2_lfd   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic       t2_busy  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin : stim
    int rd_idx;

    // 1. Reset
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check1("t1_empty", empty, 1'b1);
    check1("t1_full", full, 1'b0);
    check8("t1_data", data_out, 8'h00);
    check1("t1_busy", pkt_busy, 1'b0);

    // 2. Single packet: header 0D (len 3, addr 01), three payload bytes, parity
    for (int i = 0; i < 5; i++) wr(t2_lfd[i], t2_bytes[i]);
    for (int i = 0; i < 5; i++) begin
      rd();
      check8("t2_data", data_out, t2_bytes[i]);
      check1("t2_busy", pkt_busy, t2_busy[i]);
    end
    check1("t2_empty", empty, 1'b1);

    // 3. Full boundary: 16 writes, a dropped 17th, then drain
    for (int i = 0; i < 16; i++) wr(1'b0, 8'(i));
    check1("t3_full", full, 1'b1);
    wr(1'b0, 8'hFF);
    check1("t3_full_after_drop", full, 1'b1);
    for (int i = 0; i < 16; i++) begin
      rd();
      check8("t3_data", data_out, 8'(i));
    end
    check1("t3_empty", empty, 1'b1);
    rd();
    check8("t3_hold", data_out, 8'h0F);

    // 4. Simultaneous read and write while full: the write is dropped
    for (int i = 0; i < 16; i++) wr(1'b0, 8'h20 + 8'(i));
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hEE);
    check1("t4_full", full, 1'b0);
    check8("t4_first", data_out, 8'h20);
    for (int i = 1; i < 16; i++) begin
      rd();
      check8("t4_data", data_out, 8'h20 + 8'(i));
    end
    check1("t4_empty", empty, 1'b1);

    // 5. Soft reset mid-packet, with a write in the same cycle
    wr(1'b1, 8'h09);
    wr(1'b0, 8'hB1);
    wr(1'b0, 8'hB2);
    rd();
    check1("t5_busy", pkt_busy, 1'b1);
    check8("t5_hdr", data_out, 8'h09);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3);
    check1("t5_empty", empty, 1'b1);
    check1("t5_busy_clr", pkt_busy, 1'b0);
    check8("t5_data_clr", data_out, 8'h00);
    rd();
    check8("t5_data_hold", data_out, 8'h00);

    // 6. Pointer wrap: 40 writes with occupancy held at 8
    rd_idx = 0;
    for (int k = 0; k < 8; k++) wr(1'b0, 8'h80 + 8'(k));
    for (int k = 8; k < 40; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h80 + 8'(k));
      check8("t6_data", data_out, 8'h80 + 8'(rd_idx));
      rd_idx++;
    end
    for (int k = 0; k < 8; k++) begin
      rd();
      check8("t6_drain", data_out, 8'h80 + 8'(rd_idx));
      rd_idx++;
    end
    check1("t6_empty", empty, 1'b1);

    repeat (2) @(negedge clock);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending reads expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
